// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares the single-port unified instruction/data memory between the core
// datapath and the program loader / DMA port. One transaction per cycle is
// granted, and read data returning one cycle later is tagged back to the
// requester that issued it. The loader has priority, but a starvation counter
// forces a core grant after BURST_MAX consecutive loader grants while the
// core is waiting.
//
// Parameters
//   AW        address width
//   DW        data width
//   BURST_MAX max consecutive loader grants while the core waits (>= 1)
//
// Ports
//   clk, reset                          clock, async active-high reset
//   core_req/we/addr/wdata              core request channel
//   core_gnt, core_stall                core grant / stall (combinational)
//   core_rvalid, core_rdata             core read response
//   ld_req/we/addr/wdata                loader request channel
//   ld_gnt, ld_rvalid, ld_rdata         loader grant and read response
//   mem_en/we/addr/wdata, mem_rdata     single-port memory interface
//   owner                               owner of last granted transaction
//                                       (00 none, 01 core, 10 loader)

module unified_mem_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,

    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic [1:0]    owner
);

    localparam int unsigned CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CORE = 2'b01;
    localparam logic [1:0] OWN_LD   = 2'b10;

    typedef enum logic [1:0] {
        RD_NONE = 2'b00,
        RD_CORE = 2'b01,
        RD_LD   = 2'b10
    } rd_pend_t;

    rd_pend_t      rd_pend;
    rd_pend_t      rd_pend_nxt;
    logic [CW-1:0] ld_cnt;
    logic [CW-1:0] ld_cnt_nxt;
    logic [1:0]    owner_nxt;

    // Grant selection; reset blocks all grants so nothing reaches memory.
    always_comb begin
        core_gnt = 1'b0;
        ld_gnt   = 1'b0;
        if (!reset) begin
            if (core_req && ld_req) begin
                // Loader wins until it has used its burst allowance.
                ld_gnt   = (ld_cnt < CNT_MAX);
                core_gnt = ~(ld_cnt < CNT_MAX);
            end else begin
                core_gnt = core_req;
                ld_gnt   = ld_req;
            end
        end
    end

    // Stall must settle in-cycle; the controller samples it before the edge.
    assign core_stall = core_req & ~core_gnt & ~reset;

    // Memory port mux; idle port drives zeros.
    always_comb begin
        mem_en    = core_gnt | ld_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (ld_gnt) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    // Read data is shared; rvalid tells each consumer whether it is theirs.
    assign core_rdata = mem_rdata;
    assign ld_rdata   = mem_rdata;

    // Starvation counter: counts loader grants taken while the core waits.
    always_comb begin
        ld_cnt_nxt = ld_cnt;
        if (core_gnt || !core_req) begin
            ld_cnt_nxt = '0;
        end else if (ld_gnt && (ld_cnt != CNT_MAX)) begin
            ld_cnt_nxt = ld_cnt + CW'(1);
        end
    end

    // Owner tracks the last grant and holds across idle cycles.
    always_comb begin
        owner_nxt = owner;
        if (core_gnt) begin
            owner_nxt = OWN_CORE;
        end else if (ld_gnt) begin
            owner_nxt = OWN_LD;
        end
    end

    // Read-pending tag: next state and rvalid decode.
    always_comb begin
        rd_pend_nxt = RD_NONE;
        core_rvalid = 1'b0;
        ld_rvalid   = 1'b0;
        if (core_gnt && !core_we) begin
            rd_pend_nxt = RD_CORE;
        end else if (ld_gnt && !ld_we) begin
            rd_pend_nxt = RD_LD;
        end
        case (rd_pend)
            RD_CORE: core_rvalid = 1'b1;
            RD_LD:   ld_rvalid   = 1'b1;
            default: begin
                core_rvalid = 1'b0;
                ld_rvalid   = 1'b0;
            end
        endcase
    end

    // State registers; a reset drops any in-flight read response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= RD_NONE;
            ld_cnt  <= '0;
            owner   <= OWN_NONE;
        end else begin
            rd_pend <= rd_pend_nxt;
            ld_cnt  <= ld_cnt_nxt;
            owner   <= owner_nxt;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: two instances (BURST_MAX = 8 and 1) share
// the same stimulus. A per-instance reference model predicts every output each
// cycle; a hand-written vector table and a few multi-cycle sequences add
// independent expectations on top.

module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0, ld_addr = '0, ld_wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic        core_gnt_o[2], core_stall_o[2], core_rvalid_o[2];
    logic        ld_gnt_o[2], ld_rvalid_o[2], mem_en_o[2], mem_we_o[2];
    logic [31:0] core_rdata_o[2], ld_rdata_o[2], mem_addr_o[2], mem_wdata_o[2];
    logic [1:0]  owner_o[2];

    unified_mem_arbiter #(.AW(32), .DW(32), .BURST_MAX(8)) u0 (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt_o[0]), .core_stall(core_stall_o[0]),
        .core_rvalid(core_rvalid_o[0]), .core_rdata(core_rdata_o[0]),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt_o[0]), .ld_rvalid(ld_rvalid_o[0]), .ld_rdata(ld_rdata_o[0]),
        .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata), .owner(owner_o[0])
    );

    unified_mem_arbiter #(.AW(32), .DW(32), .BURST_MAX(1)) u1 (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt_o[1]), .core_stall(core_stall_o[1]),
        .core_rvalid(core_rvalid_o[1]), .core_rdata(core_rdata_o[1]),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt_o[1]), .ld_rvalid(ld_rvalid_o[1]), .ld_rdata(ld_rdata_o[1]),
        .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata), .owner(owner_o[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model state per instance.
    int bmax[2] = '{8, 1};
    int m_streak[2];   // loader grants in a row while core waited
    int m_pend[2];     // 0 none, 1 core read in flight, 2 loader read in flight
    int m_owner[2];
    bit m_cg[2], m_lg[2];

    // Shadow stimulus, applied at the falling edge by step().
    logic        s_rst = 1'b1, s_creq = 1'b0, s_cwe = 1'b0, s_lreq = 1'b0, s_lwe = 1'b0;
    logic [31:0] s_caddr = '0, s_cwdata = '0, s_laddr = '0, s_lwdata = '0, s_mrd = '0;

    // Observed DUT values at the last sample point.
    logic        obs_cg[2], obs_lg[2], obs_stall[2], obs_crv[2], obs_lrv[2], obs_mwe[2];
    logic [31:0] obs_maddr[2], obs_crd[2], obs_lrd[2];
    logic [1:0]  obs_owner[2];

    typedef struct {
        logic [31:0] rst, creq, cwe, caddr, cwdata;
        logic [31:0] lreq, lwe, laddr, lwdata, mrd;
        logic [31:0] e_cg, e_lg, e_mwe, e_stall, e_crv, e_lrv, e_maddr, e_owner;
    } vec_t;

    vec_t tbl[11];

    function automatic void chk(int k, string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL u%0d %s: got %0h expected %0h (t=%0t)", k, nm, act, exp, $time);
        end
    endfunction

    // One clock: drive at negedge, compare against model, advance model at posedge.
    task automatic step();
        bit          ecg, elg, ewe;
        logic [31:0] ea, ew;
        @(negedge clk);
        reset = s_rst; core_req = s_creq; core_we = s_cwe; core_addr = s_caddr;
        core_wdata = s_cwdata; ld_req = s_lreq; ld_we = s_lwe; ld_addr = s_laddr;
        ld_wdata = s_lwdata; mem_rdata = s_mrd;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_streak[k] = 0; m_pend[k] = 0; m_owner[k] = 0;
            end
            ecg = 1'b0; elg = 1'b0;
            if (!reset) begin
                if (core_req && ld_req) begin
                    elg = (m_streak[k] < bmax[k]);
                    ecg = !elg;
                end else begin
                    ecg = core_req;
                    elg = ld_req;
                end
            end
            ewe = ecg ? core_we : (elg ? ld_we : 1'b0);
            ea  = ecg ? core_addr : (elg ? ld_addr : 32'h0);
            ew  = ecg ? core_wdata : (elg ? ld_wdata : 32'h0);
            m_cg[k] = ecg; m_lg[k] = elg;
            chk(k, "core_gnt",    32'(core_gnt_o[k]),    32'(ecg));
            chk(k, "ld_gnt",      32'(ld_gnt_o[k]),      32'(elg));
            chk(k, "core_stall",  32'(core_stall_o[k]),  32'(!reset && core_req && !ecg));
            chk(k, "mem_en",      32'(mem_en_o[k]),      32'(ecg || elg));
            chk(k, "mem_we",      32'(mem_we_o[k]),      32'(ewe));
            chk(k, "mem_addr",    mem_addr_o[k],         ea);
            chk(k, "mem_wdata",   mem_wdata_o[k],        ew);
            chk(k, "core_rvalid", 32'(core_rvalid_o[k]), 32'(m_pend[k] == 1));
            chk(k, "ld_rvalid",   32'(ld_rvalid_o[k]),   32'(m_pend[k] == 2));
            chk(k, "owner",       32'(owner_o[k]),       32'(m_owner[k]));
            chk(k, "core_rdata",  core_rdata_o[k],       mem_rdata);
            chk(k, "ld_rdata",    ld_rdata_o[k],         mem_rdata);
            obs_cg[k] = core_gnt_o[k]; obs_lg[k] = ld_gnt_o[k]; obs_stall[k] = core_stall_o[k];
            obs_crv[k] = core_rvalid_o[k]; obs_lrv[k] = ld_rvalid_o[k]; obs_mwe[k] = mem_we_o[k];
            obs_maddr[k] = mem_addr_o[k]; obs_owner[k] = owner_o[k];
            obs_crd[k] = core_rdata_o[k]; obs_lrd[k] = ld_rdata_o[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_pend[k] = (m_cg[k] && !core_we) ? 1 : ((m_lg[k] && !ld_we) ? 2 : 0);
                if (m_cg[k] || !core_req) m_streak[k] = 0;
                else if (m_lg[k] && m_streak[k] < bmax[k]) m_streak[k]++;
                if (m_cg[k]) m_owner[k] = 1;
                else if (m_lg[k]) m_owner[k] = 2;
            end
        end
    endtask

    task automatic set_idle();
        s_rst = 1'b0; s_creq = 1'b0; s_cwe = 1'b0; s_lreq = 1'b0; s_lwe = 1'b0;
        s_caddr = '0; s_cwdata = '0; s_laddr = '0; s_lwdata = '0; s_mrd = '0;
    endtask

    task automatic set_both();
        set_idle();
        s_creq = 1'b1; s_caddr = 32'h500;
        s_lreq = 1'b1; s_laddr = 32'h600;
    endtask

    initial begin
        int lcount;
        bit seen;

        //          rst creq cwe caddr        cwdata  lreq lwe laddr     lwdata  mrd            cg lg we st crv lrv maddr      own
        tbl[0]  = '{1,  1,   0,  32'h10,      0,      0,   0,  0,        0,      0,             0, 0, 0, 0, 0,  0,  0,         0};
        tbl[1]  = '{0,  1,   0,  32'h10,      0,      0,   0,  0,        0,      0,             1, 0, 0, 0, 0,  0,  32'h10,    0};
        tbl[2]  = '{0,  0,   0,  0,           0,      0,   0,  0,        0,      32'hDEADBEEF,  0, 0, 0, 0, 1,  0,  0,         1};
        tbl[3]  = '{0,  0,   0,  0,           0,      1,   0,  32'h100,  0,      0,             0, 1, 0, 0, 0,  0,  32'h100,   1};
        tbl[4]  = '{0,  1,   0,  32'h200,     0,      0,   0,  0,        0,      32'hA,         1, 0, 0, 0, 0,  1,  32'h200,   2};
        tbl[5]  = '{0,  0,   0,  0,           0,      0,   0,  0,        0,      32'hB,         0, 0, 0, 0, 1,  0,  0,         1};
        tbl[6]  = '{0,  0,   0,  0,           0,      1,   0,  32'h300,  0,      0,             0, 1, 0, 0, 0,  0,  32'h300,   1};
        tbl[7]  = '{1,  0,   0,  0,           0,      0,   0,  0,        0,      32'h33,        0, 0, 0, 0, 0,  0,  0,         0};
        tbl[8]  = '{0,  1,   1,  32'h40,      32'h55, 0,   0,  0,        0,      32'h44,        1, 0, 1, 0, 0,  0,  32'h40,    0};
        tbl[9]  = '{0,  0,   0,  0,           0,      0,   0,  0,        0,      0,             0, 0, 0, 0, 0,  0,  0,         1};
        tbl[10] = '{0,  1,   0,  32'h20,      0,      1,   1,  32'h24,   32'h77, 0,             0, 1, 1, 1, 0,  0,  32'h24,    1};

        for (int i = 0; i < 11; i++) begin
            s_rst = tbl[i].rst[0]; s_creq = tbl[i].creq[0]; s_cwe = tbl[i].cwe[0];
            s_caddr = tbl[i].caddr; s_cwdata = tbl[i].cwdata;
            s_lreq = tbl[i].lreq[0]; s_lwe = tbl[i].lwe[0];
            s_laddr = tbl[i].laddr; s_lwdata = tbl[i].lwdata; s_mrd = tbl[i].mrd;
            step();
            chk(0, $sformatf("row%0d core_gnt", i),    32'(obs_cg[0]),    tbl[i].e_cg);
            chk(0, $sformatf("row%0d ld_gnt", i),      32'(obs_lg[0]),    tbl[i].e_lg);
            chk(0, $sformatf("row%0d mem_we", i),      32'(obs_mwe[0]),   tbl[i].e_mwe);
            chk(0, $sformatf("row%0d core_stall", i),  32'(obs_stall[0]), tbl[i].e_stall);
            chk(0, $sformatf("row%0d core_rvalid", i), 32'(obs_crv[0]),   tbl[i].e_crv);
            chk(0, $sformatf("row%0d ld_rvalid", i),   32'(obs_lrv[0]),   tbl[i].e_lrv);
            chk(0, $sformatf("row%0d mem_addr", i),    obs_maddr[0],      tbl[i].e_maddr);
            chk(0, $sformatf("row%0d owner", i),       32'(obs_owner[0]), tbl[i].e_owner);
            if (tbl[i].e_crv[0]) chk(0, $sformatf("row%0d core_rdata", i), obs_crd[0], tbl[i].mrd);
            if (tbl[i].e_lrv[0]) chk(0, $sformatf("row%0d ld_rdata", i),   obs_lrd[0], tbl[i].mrd);
        end

        // Continuous contention: 8 loader + 1 core for BURST_MAX=8, alternation for 1.
        set_idle();
        step();
        set_both();
        for (int i = 0; i < 27; i++) begin
            step();
            chk(0, $sformatf("burst%0d ld_gnt", i),     32'(obs_lg[0]),    32'((i % 9) < 8));
            chk(0, $sformatf("burst%0d core_stall", i), 32'(obs_stall[0]), 32'((i % 9) < 8));
            chk(1, $sformatf("alt%0d ld_gnt", i),       32'(obs_lg[1]),    32'((i % 2) == 0));
        end

        // Core drops out after 5 loader grants; the allowance starts over.
        set_idle();
        step();
        set_both();
        for (int i = 0; i < 5; i++) begin
            step();
            chk(0, $sformatf("pre%0d ld_gnt", i), 32'(obs_lg[0]), 32'd1);
        end
        s_creq = 1'b0;
        step();
        s_creq = 1'b1;
        lcount = 0;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (obs_cg[0]) seen = 1'b1;
            else if (obs_lg[0]) lcount++;
        end
        chk(0, "restart core_granted", 32'(seen), 32'd1);
        chk(0, "restart ld_grants", 32'(lcount), 32'd8);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            s_rst    = ($urandom % 80) == 0;
            s_creq   = ($urandom % 4) != 0;
            s_cwe    = ($urandom % 3) == 0;
            s_caddr  = $urandom;
            s_cwdata = $urandom;
            s_lreq   = ($urandom % 3) != 0;
            s_lwe    = ($urandom % 2) == 0;
            s_laddr  = $urandom;
            s_lwdata = $urandom;
            s_mrd    = $urandom;
            step();
            chk(0, "one_rvalid", 32'(obs_crv[0] && obs_lrv[0]), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates the single-port unified instruction/data memory of the multicycle RISC-V core between two requesters: the core datapath (fetch and load/store cycles sequenced by the controller) and the program loader / DMA port. Grants one memory transaction per cycle and routes the one-cycle-late read data back to the requester that issued it. The loader has priority, bounded by a starvation counter. The block also produces a stall signal that the core controller uses to hold PCWrite/IRWrite while the core is denied.

## Interface
- AW, 32, address width
- DW, 32, data width
- BURST_MAX, 8, max consecutive loader grants while core is waiting (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core requests a transaction this cycle
- core_we  in  1  1 = write, 0 = read
- core_addr  in  AW  core address
- core_wdata  in  DW  core write data
- core_gnt  out  1  core transaction issued this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rvalid  out  1  core_rdata valid this cycle
- core_rdata  out  DW  read data
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/AW/DW  loader equivalents
- ld_gnt, ld_rvalid  out  1  loader equivalents
- ld_rdata  out  DW  read data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  read data, valid the cycle after a read issue
- owner  out  2  owner of the last granted transaction: 00 none, 01 core, 10 loader (registered)

## Operation
- Grant logic is combinational from the current-cycle requests, ld_cnt, and reset:
  - Only one requester active: that requester is granted.
  - Both active and ld_cnt < BURST_MAX: loader is granted.
  - Both active and ld_cnt == BURST_MAX: core is granted.
  - Neither active: no grant.
  - At most one gnt is high per cycle.
- Memory port:
  - mem_en = core_gnt | ld_gnt.
  - mem_we, mem_addr, mem_wdata are muxed from the granted requester.
  - With no grant: mem_we = 0, and addr/wdata are 0.
- Starvation counter ld_cnt, width clog2(BURST_MAX+1):
  - Increments (saturating at BURST_MAX) on a loader grant while core_req = 1.
  - Clears on a core grant or whenever core_req = 0.
  - Otherwise holds.
- Read-pending state register rd_pend ∈ {NONE, CORE, LD}:
  - Next value is CORE on a core read grant, LD on a loader read grant, NONE otherwise (including writes).
  - core_rvalid = (rd_pend == CORE).
  - ld_rvalid = (rd_pend == LD).
- core_rdata and ld_rdata both pass mem_rdata through; consumers qualify with rvalid.
- Writes complete at the granting clock edge and produce no response.
- owner is updated on each grant and holds when there is no grant.

## Timing
- Request to grant: 0 cycles (same cycle). Grant to mem_en: 0 cycles.
- Read: grant in cycle N produces rvalid and data in cycle N+1.
- Back-to-back reads from alternating requesters are supported at one per cycle. rd_pend is overwritten every cycle, so no response is lost.
- While reset is asserted: core_gnt, ld_gnt, mem_en, mem_we, core_stall are forced to 0. rd_pend = NONE (both rvalid = 0), ld_cnt = 0, owner = 00.
- Reset asserted in the cycle after a read grant: the pending rvalid is dropped and is not re-issued after reset deasserts.
- First cycle after reset deassert: normal arbitration with ld_cnt = 0.
- BURST_MAX = 1: strict alternation L, C, L, C while both requesters are active.
- core_stall must settle combinationally within the same cycle; the controller samples it before the clock edge.

## Test plan
- Reset held with core_req = 1 → core_gnt = 0, mem_en = 0, core_stall = 0, owner = 00. Release reset → core_gnt = 1 and mem_en = 1 in the same cycle.
- Core read of 0x10 in cycle N, mem_rdata = 0xDEADBEEF in N+1 → core_rvalid = 1 with core_rdata = 0xDEADBEEF in N+1; ld_rvalid = 0; owner = 01.
- Both requesting continuously, BURST_MAX = 8 → repeating pattern of 8 ld_gnt then 1 core_gnt; core_stall = 1 on exactly the 8 loader cycles.
- Loader read 0x100 in N, core read 0x200 in N+1, mem returns 0xA then 0xB → ld_rvalid = 1 with 0xA in N+1; core_rvalid = 1 with 0xB in N+2; never both rvalid high in one cycle.
- Both requesting, core_req drops after 5 loader grants → ld_cnt clears. core_req reasserts → core waits 8 further loader grants before it is granted.
- Loader read granted in N, reset pulsed in N+1 → ld_rvalid = 0 in N+1 and N+2; ld_cnt = 0; a core write afterwards is granted immediately with mem_we = 1.
